datapath_p2: RTL and testbench
==============================

# datapath_p2

Single-bus 32-bit processor datapath with general registers R0–R15, PC, IR, MAR, MDR, HI/LO, Y, 64-bit Z, an ALU, the select-and-encode logic, the conditional-branch (CON) flip-flop, and input/output ports. An external control unit or testbench drives one-hot register strobes and bus-drive controls each clock. Memory is external: read data arrives on `Mdatain`.

## Interface
- No parameters.
- `Clock`  in  1  single system clock; all state changes on its rising edge.
- `Clear`  in  1  synchronous, active-high reset.
- `outp`  out  32  Out.Port register contents.
- `PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout`  in  1 each  drive PC, Z[63:32], Z[31:0], MDR, HI, LO, or In.Port onto the bus.
- `MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin`  in  1 each  load the named register from the bus. `Zin` loads Z from the ALU.
- `IncPC`  in  1  ALU computes bus+1 regardless of opcode.
- `Read`  in  1  MDR input mux selects `Mdatain`; otherwise the bus.
- `Write`  in  1  memory write request; no internal effect.
- `Gra, Grb, Grc`  in  1 each  select the register field Ra, Rb, or Rc of IR.
- `Rin, Rout, BAout`  in  1 each  load, drive, or base-address-drive the selected register.
- `Cout`  in  1  drive the sign-extended IR constant onto the bus.
- `CONIn`  in  1  load the CON flip-flop.
- `Strobe`  in  1  load In.Port from `InPort_data`.
- `Mdatain`  in  32  memory read data.
- `InPort_data`  in  32  external input-port data.

## Operation
- **Bus source:** one source is driven at a time. If several are asserted, the fixed priority is:
  - R (via Rout or BAout), HI, LO, Zhi, Zlo, PC, MDR, InPort, C.
  - If none is asserted, the bus is 0.
- **Select/encode:** IR fields are opcode = IR[31:27], Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15].
  - Register index = OR of the fields gated by Gra, Grb, Grc.
  - Under `BAout`, R0 reads as 0.
  - C = sign-extend(IR[18:0]).
- **ALU:** A = Y, B = bus, result is 64 bits into Z.
  - Operation is chosen by opcode: add 00011, sub 00100, and 00101, or 00110, shr 00111, shra 01000, shl 01001, ror 01010, rol 01011, addi 01100, andi 01101, ori 01110, mul 01111 (signed 64-bit), neg 10000 (−B), not 10001 (~B).
  - Branch opcode 10010 and all other opcodes perform add.
  - Shift and rotate amounts are B[4:0].
  - For every operation except mul, Z[63:32] = 0.
  - `IncPC` overrides the opcode: Z = {32'b0, B+1}.
- **CON:** C2 = IR[20:19]. On `CONIn` the flip-flop loads the bus value tested as follows:
  - 00: value == 0
  - 01: value != 0
  - 10: value[31] == 0
  - 11: value[31] == 1
- **PC load:** PC loads from the bus on `PCin`. When opcode = 10010, the load happens only if CON = 1.
- **Registers:** every register (R0–R15, PC, IR, MAR, MDR, HI, LO, Y, Z, In.Port, Out.Port, CON) resets to 0 on `Clear`.
  - `outp` reset value is 0.
  - R0 is a normal writable register; it only reads as 0 under `BAout`.

## Timing
- All register loads, CON, and `Clear` act at the rising `Clock` edge, using controls sampled at that edge.
- `Clear` has priority over every load. Clearing mid-instruction zeroes all state on that edge.
- Bus, ALU, select/encode, and CON-test logic are purely combinational, with zero-cycle latency. A register loaded at edge N is visible on the bus after edge N.
- A register may drive the bus and load from it in the same cycle; it captures the old value's bus result.
- The MDR mux is combinational: with `Read`=1 and `MDRin`=1, MDR captures `Mdatain` at the edge.
- Adding the ALU result to Z takes one cycle; Z→PC takes one more.
- Add wrap-around is modulo 2^32. Z[63:32] carries no overflow.

## Test plan
- **Reset:** assert `Clear` for one edge with arbitrary controls → PC, IR, all R, Z, and `outp` are 0.
- **Fetch:** PC=0. Apply PCout+MARin+IncPC+Zin, then Zlowout+PCin+Read+MDRin with `Mdatain`=0x91000023, then MDRout+IRin → PC=1, MAR=0, IR=0x91000023.
- **brzr taken:** IR as above, R2=0.
  - Apply Gra+Rout+CONIn → CON=1.
  - Apply PCout+Yin, then Cout+Zin → Z=36.
  - Apply Zlowout+PCin → PC=36.
- **brzr not taken:** same sequence with R2=5 → CON=0, Z=36, PC stays 1.
- **add:** IR=0x19A20000 (add R3,R4,R4) with R4=7.
  - Apply Grb+Rout+Yin, then Grc+Rout+Zin, then Zlowout+Gra+Rin → R3=14.
  - Repeat with R4=0xFFFFFFFF → R3=0xFFFFFFFE, Zhi=0.
- **Ports:** `InPort_data`=0xABCD with `Strobe`, then InPortout+OutPortin → `outp`=0xABCD.

Source files
------------

// File: rtl/datapath_p2.sv
// datapath_p2: single-bus 32-bit datapath with R0-R15, PC/IR/MAR/MDR, HI/LO, Y/Z, ALU,
// select-and-encode logic, conditional-branch flip-flop and in/out ports.
module datapath_p2 (
    input  logic        Clock,
    input  logic        Clear,
    output logic [31:0] outp,
    input  logic        PCout,
    input  logic        Zhiout,
    input  logic        Zlowout,
    input  logic        MDRout,
    input  logic        HIout,
    input  logic        LOout,
    input  logic        InPortout,
    input  logic        MARin,
    input  logic        Zin,
    input  logic        PCin,
    input  logic        MDRin,
    input  logic        IRin,
    input  logic        Yin,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        OutPortin,
    input  logic        IncPC,
    input  logic        Read,
    input  logic        Write,
    input  logic        Gra,
    input  logic        Grb,
    input  logic        Grc,
    input  logic        Rin,
    input  logic        Rout,
    input  logic        BAout,
    input  logic        Cout,
    input  logic        CONIn,
    input  logic        Strobe,
    input  logic [31:0] Mdatain,
    input  logic [31:0] InPort_data
);
    typedef enum logic [4:0] {
        OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101, OP_OR   = 5'b00110,
        OP_SHR  = 5'b00111, OP_SHRA = 5'b01000, OP_SHL  = 5'b01001, OP_ROR  = 5'b01010,
        OP_ROL  = 5'b01011, OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110,
        OP_MUL  = 5'b01111, OP_NEG  = 5'b10000, OP_NOT  = 5'b10001, OP_BR   = 5'b10010
    } op_e;

    logic [31:0] r_q [16];
    logic [31:0] pc_q, ir_q, mar_q, mdr_q, hi_q, lo_q, y_q, inport_q, outport_q;
    logic [63:0] z_q;
    logic        con_q;

    logic [31:0] mdr_d;
    logic        con_d;
    logic [4:0]  opcode;
    logic [3:0]  sel;
    logic [31:0] r_bus, c_sext, bus;
    logic [63:0] alu, rot_r, rot_l;
    logic signed [63:0] y_ext, b_ext, prod;
    logic        pc_load;

    assign opcode = ir_q[31:27];
    assign sel    = ({4{Gra}} & ir_q[26:23]) | ({4{Grb}} & ir_q[22:19]) | ({4{Grc}} & ir_q[18:15]);
    assign r_bus  = (BAout && sel == 4'd0) ? '0 : r_q[sel];
    assign c_sext = {{13{ir_q[18]}}, ir_q[18:0]};

    always_comb begin
        if (Rout || BAout)  bus = r_bus;
        else if (HIout)     bus = hi_q;
        else if (LOout)     bus = lo_q;
        else if (Zhiout)    bus = z_q[63:32];
        else if (Zlowout)   bus = z_q[31:0];
        else if (PCout)     bus = pc_q;
        else if (MDRout)    bus = mdr_q;
        else if (InPortout) bus = inport_q;
        else if (Cout)      bus = c_sext;
        else                bus = '0;
    end

    // Rotates fall out of shifting a doubled copy of Y
    assign rot_r = {y_q, y_q} >> bus[4:0];
    assign rot_l = {y_q, y_q} << bus[4:0];
    assign y_ext = {{32{y_q[31]}}, y_q};
    assign b_ext = {{32{bus[31]}}, bus};
    assign prod  = y_ext * b_ext;

    always_comb begin
        alu = '0;
        if (IncPC) begin
            alu[31:0] = bus + 32'd1;
        end else begin
            case (opcode)
                OP_SUB:          alu[31:0] = y_q - bus;
                OP_AND, OP_ANDI: alu[31:0] = y_q & bus;
                OP_OR, OP_ORI:   alu[31:0] = y_q | bus;
                OP_SHR:          alu[31:0] = y_q >> bus[4:0];
                OP_SHRA:         alu[31:0] = $signed(y_q) >>> bus[4:0];
                OP_SHL:          alu[31:0] = y_q << bus[4:0];
                OP_ROR:          alu[31:0] = rot_r[31:0];
                OP_ROL:          alu[31:0] = rot_l[63:32];
                OP_MUL:          alu       = prod;
                OP_NEG:          alu[31:0] = -bus;
                OP_NOT:          alu[31:0] = ~bus;
                default:         alu[31:0] = y_q + bus;
            endcase
        end
    end

    always_comb begin
        case (ir_q[20:19])
            2'b00:   con_d = (bus == '0);
            2'b01:   con_d = (bus != '0);
            2'b10:   con_d = ~bus[31];
            default: con_d = bus[31];
        endcase
    end

    assign mdr_d   = Read ? Mdatain : bus;
    assign pc_load = PCin && (opcode != OP_BR || con_q);

    always_ff @(posedge Clock) begin
        if (Clear) begin
            for (int unsigned i = 0; i < 16; i++) r_q[i] <= '0;
            pc_q      <= '0;
            ir_q      <= '0;
            mar_q     <= '0;
            mdr_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            y_q       <= '0;
            z_q       <= '0;
            inport_q  <= '0;
            outport_q <= '0;
            con_q     <= 1'b0;
        end else begin
            if (Rin)       r_q[sel]  <= bus;
            if (pc_load)   pc_q      <= bus;
            if (IRin)      ir_q      <= bus;
            if (MARin)     mar_q     <= bus;
            if (MDRin)     mdr_q     <= mdr_d;
            if (HIin)      hi_q      <= bus;
            if (LOin)      lo_q      <= bus;
            if (Yin)       y_q       <= bus;
            if (Zin)       z_q       <= alu;
            if (Strobe)    inport_q  <= InPort_data;
            if (OutPortin) outport_q <= bus;
            if (CONIn)     con_q     <= con_d;
        end
    end

    assign outp = outport_q;

    // MAR and Write address external memory, which is not modelled here
    logic unused_mem;
    assign unused_mem = ^{mar_q, Write};
endmodule

// File: tb/tb_datapath_p2.sv
// Directed self-checking bench for datapath_p2: reset, fetch, branches, ALU ops, bus and ports.
module tb_datapath_p2;
    logic        Clock, Clear;
    logic [31:0] outp;
    logic PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout;
    logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin;
    logic IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn, Strobe;
    logic [31:0] Mdatain, InPort_data;

    int tests = 0;
    int fails = 0;

    datapath_p2 dut (
        .Clock(Clock), .Clear(Clear), .outp(outp),
        .PCout(PCout), .Zhiout(Zhiout), .Zlowout(Zlowout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .InPortout(InPortout),
        .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
        .Yin(Yin), .HIin(HIin), .LOin(LOin), .OutPortin(OutPortin),
        .IncPC(IncPC), .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout), .CONIn(CONIn),
        .Strobe(Strobe), .Mdatain(Mdatain), .InPort_data(InPort_data)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic idle();
        {Clear, PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout} = '0;
        {MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin} = '0;
        {IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn, Strobe} = '0;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        idle();
    endtask

    task automatic load_ir(input logic [31:0] v);
        Mdatain = v; Read = 1; MDRin = 1; tick();
        MDRout = 1; IRin = 1; tick();
    endtask

    task automatic set_inport(input logic [31:0] v);
        InPort_data = v; Strobe = 1; tick();
    endtask

    task automatic test_reset();
        Clear = 1; PCout = 1; PCin = 1; Zin = 1; IncPC = 1; IRin = 1; OutPortin = 1;
        Gra = 1; Rin = 1; Strobe = 1; InPort_data = 32'hDEAD_BEEF; CONIn = 1;
        tick();
        tests++; if (dut.pc_q !== 32'h0) begin fails++; $display("FAIL reset_pc got=%h exp=0", dut.pc_q); end
        tests++; if (dut.ir_q !== 32'h0) begin fails++; $display("FAIL reset_ir got=%h exp=0", dut.ir_q); end
        tests++; if (dut.z_q !== 64'h0) begin fails++; $display("FAIL reset_z got=%h exp=0", dut.z_q); end
        tests++; if (outp !== 32'h0) begin fails++; $display("FAIL reset_outp got=%h exp=0", outp); end
        tests++; if (dut.con_q !== 1'b0) begin fails++; $display("FAIL reset_con got=%b exp=0", dut.con_q); end
        for (int i = 0; i < 16; i++) begin
            tests++;
            if (dut.r_q[i] !== 32'h0) begin fails++; $display("FAIL reset_r%0d got=%h exp=0", i, dut.r_q[i]); end
        end
    endtask

    task automatic test_fetch();
        PCout = 1; MARin = 1; IncPC = 1; Zin = 1; tick();
        Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'h9100_0023; tick();
        MDRout = 1; IRin = 1; tick();
        tests++; if (dut.pc_q !== 32'd1) begin fails++; $display("FAIL fetch_pc got=%h exp=1", dut.pc_q); end
        tests++; if (dut.mar_q !== 32'd0) begin fails++; $display("FAIL fetch_mar got=%h exp=0", dut.mar_q); end
        tests++; if (dut.ir_q !== 32'h9100_0023) begin fails++; $display("FAIL fetch_ir got=%h exp=91000023", dut.ir_q); end
    endtask

    task automatic test_brzr(input logic [31:0] r2, input logic exp_con, input logic [31:0] exp_pc);
        load_ir(32'h0);
        set_inport(32'd1);
        InPortout = 1; PCin = 1; tick();
        load_ir(32'h9100_0023);
        set_inport(r2);
        InPortout = 1; Gra = 1; Rin = 1; tick();
        Gra = 1; Rout = 1; CONIn = 1; tick();
        tests++; if (dut.con_q !== exp_con) begin fails++; $display("FAIL brzr_con r2=%h got=%b exp=%b", r2, dut.con_q, exp_con); end
        PCout = 1; Yin = 1; tick();
        Cout = 1; Zin = 1; tick();
        tests++; if (dut.z_q !== 64'd36) begin fails++; $display("FAIL brzr_z got=%h exp=36", dut.z_q); end
        Zlowout = 1; PCin = 1; tick();
        tests++; if (dut.pc_q !== exp_pc) begin fails++; $display("FAIL brzr_pc got=%h exp=%h", dut.pc_q, exp_pc); end
    endtask

    task automatic test_add(input logic [31:0] r4, input logic [31:0] exp_r3);
        load_ir(32'h19A2_0000);
        set_inport(r4);
        InPortout = 1; Grb = 1; Rin = 1; tick();
        Grb = 1; Rout = 1; Yin = 1; tick();
        Grc = 1; Rout = 1; Zin = 1; tick();
        Zlowout = 1; Gra = 1; Rin = 1; tick();
        Gra = 1; Rout = 1; OutPortin = 1; tick();
        tests++; if (outp !== exp_r3) begin fails++; $display("FAIL add_r3 r4=%h got=%h exp=%h", r4, outp, exp_r3); end
        Zhiout = 1; OutPortin = 1; tick();
        tests++; if (outp !== 32'h0) begin fails++; $display("FAIL add_zhi got=%h exp=0", outp); end
    endtask

    task automatic test_ports();
        set_inport(32'h0000_ABCD);
        InPortout = 1; OutPortin = 1; tick();
        tests++; if (outp !== 32'h0000_ABCD) begin fails++; $display("FAIL ports_outp got=%h exp=0000abcd", outp); end
    endtask

    typedef struct packed {
        logic [4:0]  op;
        logic        inc;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] z;
    } vec_t;

    task automatic test_alu_ops();
        vec_t v [15];
        v[0]  = '{5'b00100, 1'b0, 32'd10,         32'd3,         64'd7};
        v[1]  = '{5'b00101, 1'b0, 32'h0000_F0F0,  32'h0000_0FF0, 64'h0000_00F0};
        v[2]  = '{5'b00110, 1'b0, 32'h0000_F000,  32'h0000_000F, 64'h0000_F00F};
        v[3]  = '{5'b00111, 1'b0, 32'h8000_0000,  32'd4,         64'h0800_0000};
        v[4]  = '{5'b01000, 1'b0, 32'h8000_0000,  32'd4,         64'hF800_0000};
        v[5]  = '{5'b01001, 1'b0, 32'd1,          32'd31,        64'h8000_0000};
        v[6]  = '{5'b01010, 1'b0, 32'd1,          32'd4,         64'h1000_0000};
        v[7]  = '{5'b01011, 1'b0, 32'h8000_0001,  32'd1,         64'h0000_0003};
        v[8]  = '{5'b01111, 1'b0, 32'hFFFF_FFFE,  32'd3,         64'hFFFF_FFFF_FFFF_FFFA};
        v[9]  = '{5'b01111, 1'b0, 32'h0001_0000,  32'h0001_0000, 64'h0000_0001_0000_0000};
        v[10] = '{5'b10000, 1'b0, 32'd0,          32'd5,         64'h0000_0000_FFFF_FFFB};
        v[11] = '{5'b10001, 1'b0, 32'd0,          32'h0F0F_0F0F, 64'h0000_0000_F0F0_F0F0};
        v[12] = '{5'b11111, 1'b0, 32'd2,          32'd3,         64'd5};
        v[13] = '{5'b01111, 1'b1, 32'hFFFF_FFFE,  32'hFFFF_FFFF, 64'd0};
        v[14] = '{5'b00011, 1'b0, 32'hFFFF_FFFF,  32'd2,         64'd1};
        for (int i = 0; i < 15; i++) begin
            load_ir({v[i].op, 27'h0});
            set_inport(v[i].a);
            InPortout = 1; Yin = 1; tick();
            set_inport(v[i].b);
            InPortout = 1; Zin = 1; IncPC = v[i].inc; tick();
            tests++;
            if (dut.z_q !== v[i].z) begin
                fails++;
                $display("FAIL alu_vec%0d op=%b got=%h exp=%h", i, v[i].op, dut.z_q, v[i].z);
            end
        end
    endtask

    task automatic test_bus_priority();
        load_ir(32'h0);
        OutPortin = 1; tick();
        tests++; if (outp !== 32'h0) begin fails++; $display("FAIL bus_idle got=%h exp=0", outp); end
        set_inport(32'h0000_0055);
        InPortout = 1; Gra = 1; Rin = 1; tick();
        Gra = 1; BAout = 1; OutPortin = 1; tick();
        tests++; if (outp !== 32'h0) begin fails++; $display("FAIL ba_r0 got=%h exp=0", outp); end
        Gra = 1; Rout = 1; OutPortin = 1; tick();
        tests++; if (outp !== 32'h55) begin fails++; $display("FAIL rout_r0 got=%h exp=55", outp); end
        Gra = 1; Rout = 1; PCout = 1; InPortout = 1; OutPortin = 1; tick();
        tests++; if (outp !== 32'h55) begin fails++; $display("FAIL prio_r got=%h exp=55", outp); end
        set_inport(32'h0000_0011);
        InPortout = 1; HIin = 1; tick();
        set_inport(32'h0000_0022);
        HIout = 1; LOout = 1; InPortout = 1; OutPortin = 1; tick();
        tests++; if (outp !== 32'h11) begin fails++; $display("FAIL prio_hi got=%h exp=11", outp); end
        InPortout = 1; LOin = 1; tick();
        LOout = 1; PCout = 1; OutPortin = 1; tick();
        tests++; if (outp !== 32'h22) begin fails++; $display("FAIL prio_lo got=%h exp=22", outp); end
        load_ir(32'h0004_0000);
        Cout = 1; OutPortin = 1; tick();
        tests++; if (outp !== 32'hFFFC_0000) begin fails++; $display("FAIL c_sext got=%h exp=fffc0000", outp); end
    endtask

    task automatic test_con_modes();
        logic exp_neg [4];
        logic exp_zero [4];
        exp_neg  = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_zero = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int c = 0; c < 4; c++) begin
            load_ir(32'h9000_0000 | (32'(c) << 19));
            set_inport(32'h8000_0000);
            InPortout = 1; CONIn = 1; tick();
            tests++;
            if (dut.con_q !== exp_neg[c]) begin fails++; $display("FAIL con_neg c2=%0d got=%b exp=%b", c, dut.con_q, exp_neg[c]); end
            set_inport(32'h0);
            InPortout = 1; CONIn = 1; tick();
            tests++;
            if (dut.con_q !== exp_zero[c]) begin fails++; $display("FAIL con_zero c2=%0d got=%b exp=%b", c, dut.con_q, exp_zero[c]); end
        end
    endtask

    initial begin
        idle();
        Mdatain = '0;
        InPort_data = '0;
        @(posedge Clock); #1;
        test_reset();
        test_fetch();
        test_brzr(32'd0, 1'b1, 32'd36);
        test_brzr(32'd5, 1'b0, 32'd1);
        test_add(32'd7, 32'd14);
        test_add(32'hFFFF_FFFF, 32'hFFFF_FFFE);
        test_ports();
        test_alu_ops();
        test_bus_priority();
        test_con_modes();
        test_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
